pc_register: RTL and testbench

- Program-counter state element sitting directly downstream of the next-PC source multiplexer in the multicycle CPU.
- Captures the mux output (`next_pc`) under control of the main FSM's PC-write signals and branch outcome.
- Drives `pc` to instruction memory, and `pc_plus4` / `jump_target` back to the mux inputs.
- Flags misaligned PC loads and counts PC updates for debug.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/pc_trace_buf.sv | 56 +++++
 rtl/pc_register.sv | 99 +++++++++
 tb/tb_pc_register.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions used by the PC register and its neighbours.
// Latency: none (types and constants only).
// Backpressure: not applicable.
//
// Contents: word width, PC alignment mask, default reset PC and the
// next-PC source mux select encoding.
package cpu_pkg;

  localparam int WORD_W = 32;

  // Low PC bits that must be zero for a word-aligned fetch address.
  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

  localparam logic [WORD_W-1:0] RESET_PC_DFLT = 32'h0000_0000;

  // Select encoding of the next-PC source mux feeding pc_register.next_pc.
  typedef enum logic [1:0] {
    PC_SRC_PLUS4  = 2'd0,
    PC_SRC_ALU    = 2'd1,
    PC_SRC_ALUOUT = 2'd2,
    PC_SRC_JUMP   = 2'd3
  } pc_src_e;

endpackage

// File: rtl/pc_trace_buf.sv
// Circular history of the last DEPTH program-counter values replaced by an update.
// Latency: push lands on the next rising edge; read is combinational.
// Backpressure: none; push is accepted every cycle it is asserted, oldest entry overwritten.
//
// Ports: clk, rst_n (async active-low), push / push_pc (value to record),
//        rd_idx (0 = most recent push), rd_pc (selected entry).
// Only compiled when PC_TRACE_EN is defined.
`ifdef PC_TRACE_EN
module pc_trace_buf
  import cpu_pkg::*;
#(
  parameter int                DEPTH     = 8,
  parameter logic [WORD_W-1:0] RESET_VAL = RESET_PC_DFLT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WORD_W-1:0]        push_pc,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WORD_W-1:0]        rd_pc
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     wr_ptr_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_pc;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // wr_ptr_q points at the next free slot, so the newest entry sits one
  // behind it; DEPTH is a power of two so the subtraction wraps for free.
  assign rd_pc = mem_q[wr_ptr_q - AW'(1) - rd_idx];

endmodule
`endif

// File: rtl/pc_register.sv
// Program counter: captures the next-PC mux output under FSM/branch control, flags misaligned loads.
// Latency: accepted load visible on pc one cycle later; pc_plus4/jump_target combinational from pc.
// Backpressure: none; misaligned loads are dropped (pc holds) and latch the sticky misalign_err.
//
// Ports: clk, rst_n (async active-low), next_pc, pc_write, pc_write_cond,
//        branch_ne, zero, instr_index -> pc, pc_plus4, jump_target,
//        misalign_err, update_cnt; trace_idx/trace_pc only with PC_TRACE_EN.
// Optional macro PC_TRACE_EN adds a TRACE_DEPTH-entry history of replaced PCs.
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC    = RESET_PC_DFLT,
  parameter int                CNT_W       = 32,
  parameter int                TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WORD_W-1:0]              next_pc,
  input  logic                           pc_write,
  input  logic                           pc_write_cond,
  input  logic                           branch_ne,
  input  logic                           zero,
  input  logic [25:0]                    instr_index,
  output logic [WORD_W-1:0]              pc,
  output logic [WORD_W-1:0]              pc_plus4,
  output logic [WORD_W-1:0]              jump_target,
  output logic                           misalign_err,
  output logic [CNT_W-1:0]               update_cnt
`ifdef PC_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [WORD_W-1:0]              trace_pc
`endif
);

  if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_register: TRACE_DEPTH must be a power of two >= 2");
  end

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  update_cnt_q, update_cnt_d;
  logic              misalign_err_q, misalign_err_d;

  logic ld;
  logic aligned;
  logic accept;

  // BEQ takes on zero, BNE on !zero: zero ^ branch_ne covers both.
  // pc_write ORs in on top, so it wins regardless of the branch outcome.
  assign ld      = pc_write | (pc_write_cond & (zero ^ branch_ne));
  assign aligned = (next_pc[1:0] & PC_ALIGN_MASK) == 2'b00;
  assign accept  = ld & aligned;

  always_comb begin
    pc_d           = pc_q;
    update_cnt_d   = update_cnt_q;
    misalign_err_d = misalign_err_q;
    if (accept) begin
      pc_d         = next_pc;
      update_cnt_d = update_cnt_q + CNT_W'(1);
    end else if (ld) begin
      misalign_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      update_cnt_q   <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      update_cnt_q   <= update_cnt_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign jump_target  = {pc_q[31:28], instr_index, 2'b00};
  assign misalign_err = misalign_err_q;
  assign update_cnt   = update_cnt_q;

`ifdef PC_TRACE_EN
  // The outgoing PC is recorded, so the history holds where we came from.
  pc_trace_buf #(
    .DEPTH     (TRACE_DEPTH),
    .RESET_VAL (RESET_PC)
  ) u_trace (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .push_pc (pc_q),
    .rd_idx  (trace_idx),
    .rd_pc   (trace_pc)
  );
`endif

endmodule

// File: tb/tb_pc_register.sv
// Directed bench for pc_register: reset, unconditional/conditional loads,
// combinational outputs, misalignment, async reset and (optionally) the trace buffer.
module tb_pc_register;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          TD     = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        pc_write;
  logic        pc_write_cond;
  logic        branch_ne;
  logic        zero;
  logic [25:0] instr_index;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic        misalign_err;
  logic [31:0] update_cnt;
`ifdef PC_TRACE_EN
  logic [1:0]  trace_idx;
  logic [31:0] trace_pc;
`endif

  int n_vec = 0;
  int n_err = 0;

  pc_register #(
    .RESET_PC    (RST_PC),
    .CNT_W       (32),
    .TRACE_DEPTH (TD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .next_pc       (next_pc),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .zero          (zero),
    .instr_index   (instr_index),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .jump_target   (jump_target),
    .misalign_err  (misalign_err),
    .update_cnt    (update_cnt)
`ifdef PC_TRACE_EN
    ,
    .trace_idx     (trace_idx),
    .trace_pc      (trace_pc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    next_pc       = '0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    zero          = 1'b0;
    instr_index   = '0;
`ifdef PC_TRACE_EN
    trace_idx     = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_pc",     pc,           32'h0000_3000);
    check("rst_plus4",  pc_plus4,     32'h0000_3004);
    check("rst_cnt",    update_cnt,   32'd0);
    check("rst_err",    misalign_err, 1'b0);
    check("rst_jump",   jump_target,  32'h0000_0000);

`ifdef PC_TRACE_EN
    check("trc_rst", trace_pc, 32'h0000_3000);
    pc_write = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      next_pc = 32'(i * 4);
      step();
    end
    pc_write = 1'b0;
    check("trc_pc", pc, 32'h0000_0014);
    trace_idx = 2'd0; #1; check("trc_idx0", trace_pc, 32'h0000_0010);
    trace_idx = 2'd1; #1; check("trc_idx1", trace_pc, 32'h0000_000C);
    trace_idx = 2'd2; #1; check("trc_idx2", trace_pc, 32'h0000_0008);
    trace_idx = 2'd3; #1; check("trc_idx3", trace_pc, 32'h0000_0004);
    // A rejected load must not be recorded.
    trace_idx = 2'd0;
    pc_write  = 1'b1;
    next_pc   = 32'h0000_0016;
    step();
    pc_write  = 1'b0;
    check("trc_rej", trace_pc, 32'h0000_0010);
    // Back to reset state for the main sequence.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("trc_rst2", trace_pc, 32'h0000_3000);
`endif

    // Unconditional load, then hold
    pc_write = 1'b1;
    next_pc  = 32'h0000_0010;
    step();
    pc_write = 1'b0;
    check("ld_pc",  pc,         32'h0000_0010);
    check("ld_cnt", update_cnt, 32'd1);
    repeat (3) step();
    check("hold_pc",  pc,         32'h0000_0010);
    check("hold_cnt", update_cnt, 32'd1);

    // Conditional loads
    pc_write_cond = 1'b1; branch_ne = 1'b0; zero = 1'b0; next_pc = 32'h0000_0040;
    step();
    check("beq_nt_pc", pc, 32'h0000_0010);
    zero = 1'b1;
    step();
    check("beq_t_pc",  pc,         32'h0000_0040);
    check("beq_t_cnt", update_cnt, 32'd2);
    branch_ne = 1'b1; zero = 1'b0; next_pc = 32'h0000_0080;
    step();
    check("bne_t_pc", pc, 32'h0000_0080);
    zero = 1'b1; next_pc = 32'h0000_00C0;
    step();
    check("bne_nt_pc",  pc,         32'h0000_0080);
    check("bne_nt_cnt", update_cnt, 32'd3);

    // Unconditional write wins over a not-taken branch
    pc_write = 1'b1; next_pc = 32'hA000_0000;
    step();
    pc_write_cond = 1'b0; branch_ne = 1'b0; zero = 1'b0;
    check("both_pc",  pc,         32'hA000_0000);
    check("both_cnt", update_cnt, 32'd4);
    instr_index = 26'h3FF_FFFF;
    #1;
    check("jump_tgt",  jump_target, 32'hAFFF_FFFC);
    check("plus4_mid", pc_plus4,    32'hA000_0004);

    // pc + 4 wrap, then self-loop counts as an update
    next_pc = 32'hFFFF_FFFC;
    step();
    check("wrap_pc",    pc,          32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4,    32'h0000_0000);
    check("wrap_jump",  jump_target, 32'hFFFF_FFFC);
    step();
    check("self_pc",  pc,         32'hFFFF_FFFC);
    check("self_cnt", update_cnt, 32'd6);

    // Misaligned load
    next_pc = 32'h0000_0102;
    step();
    check("mis_pc",  pc,           32'hFFFF_FFFC);
    check("mis_err", misalign_err, 1'b1);
    check("mis_cnt", update_cnt,   32'd6);
    for (int i = 0; i < 10; i++) begin
      next_pc = 32'h0000_0100 + 32'(i * 4);
      step();
      check("mis_sticky", misalign_err, 1'b1);
    end
    check("post_pc",  pc,         32'h0000_0124);
    check("post_cnt", update_cnt, 32'd16);

    // Asynchronous reset mid-cycle with a load pending
    next_pc = 32'h0000_0200;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc",    pc,           32'h0000_3000);
    check("arst_plus4", pc_plus4,     32'h0000_3004);
    check("arst_cnt",   update_cnt,   32'd0);
    check("arst_err",   misalign_err, 1'b0);
    step();
    check("arst_hold_pc", pc, 32'h0000_3000);
    @(negedge clk);
    pc_write = 1'b0;
    rst_n    = 1'b1;
    step();
    check("rel_pc",  pc,         32'h0000_3000);
    check("rel_cnt", update_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
